// File: rtl/seq_mag_comp_if.sv
// Request/result bundle for the sequential magnitude comparator.
// master drives the operands and start; slave returns busy/done and the eq/gt/lt result.
interface seq_mag_comp_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/seq_mag_comp.sv
// Multi-cycle MSB-first magnitude compare, DIGIT bits per clock, unsigned or two's-complement.
// Latency: done k cycles after the start edge (k=NDIG, or first differing digit+1 with SEQCOMP_EARLY_EXIT_EN).
// Backpressure: start is ignored while busy; a new start is accepted in the done cycle.
module seq_mag_comp #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mag_comp_if.slave cmp
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NDIG - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("seq_mag_comp: WIDTH must be >= 2 and an exact multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx;
    logic             decided;
    logic             dec_gt;
    logic             busy_q;
    logic             done_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             dig_ne;
    logic             dig_gt;
    logic             last_dig;
    logic             res_decided;
    logic             res_gt;
    logic             scan_exit;

    // Operands shift left each SCAN step, so the current digit is always the top one.
    always_comb begin
        a_dig       = a_q[WIDTH-1 -: DIGIT];
        b_dig       = b_q[WIDTH-1 -: DIGIT];
        dig_ne      = (a_dig != b_dig);
        dig_gt      = (a_dig > b_dig);
        last_dig    = (idx == LAST_IDX);
        res_decided = decided | dig_ne;
        res_gt      = decided ? dec_gt : dig_gt;
`ifdef SEQCOMP_EARLY_EXIT_EN
        scan_exit   = last_dig | dig_ne;
`else
        scan_exit   = last_dig;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (cmp.start) begin
                        // Flipping both MSBs maps two's-complement order onto unsigned order.
                        a_q     <= cmp.signed_mode ? (cmp.a ^ MSB_MASK) : cmp.a;
                        b_q     <= cmp.signed_mode ? (cmp.b ^ MSB_MASK) : cmp.b;
                        idx     <= '0;
                        decided <= 1'b0;
                        dec_gt  <= 1'b0;
                        busy_q  <= 1'b1;
                        eq_q    <= 1'b0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        state   <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (scan_exit) begin
                        eq_q   <= ~res_decided;
                        gt_q   <= res_decided & res_gt;
                        lt_q   <= res_decided & ~res_gt;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx     <= idx + 1'b1;
                        a_q     <= a_q << DIGIT;
                        b_q     <= b_q << DIGIT;
                        decided <= res_decided;
                        dec_gt  <= res_gt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmp.busy = busy_q;
    assign cmp.done = done_q;
    assign cmp.eq   = eq_q;
    assign cmp.gt   = gt_q;
    assign cmp.lt   = lt_q;
endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed and swept checks of seq_mag_comp (16/4 plus 8/1, 8/2, 8/8 instances).
// Honours SEQCOMP_EARLY_EXIT_EN when computing expected latencies.
module tb_seq_mag_comp;
`ifdef SEQCOMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    seq_mag_comp_if #(.WIDTH(16)) c16 ();
    seq_mag_comp_if #(.WIDTH(8))  c81 ();
    seq_mag_comp_if #(.WIDTH(8))  c82 ();
    seq_mag_comp_if #(.WIDTH(8))  c88 ();

    seq_mag_comp #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst_n(rst_n), .cmp(c16));
    seq_mag_comp #(.WIDTH(8),  .DIGIT(1)) u81 (.clk(clk), .rst_n(rst_n), .cmp(c81));
    seq_mag_comp #(.WIDTH(8),  .DIGIT(2)) u82 (.clk(clk), .rst_n(rst_n), .cmp(c82));
    seq_mag_comp #(.WIDTH(8),  .DIGIT(8)) u88 (.clk(clk), .rst_n(rst_n), .cmp(c88));

    logic       sw_start;
    logic [7:0] sw_a;
    logic [7:0] sw_b;
    logic       sw_sm;
    assign c81.start = sw_start; assign c81.a = sw_a; assign c81.b = sw_b; assign c81.signed_mode = sw_sm;
    assign c82.start = sw_start; assign c82.a = sw_a; assign c82.b = sw_b; assign c82.signed_mode = sw_sm;
    assign c88.start = sw_start; assign c88.a = sw_a; assign c88.b = sw_b; assign c88.signed_mode = sw_sm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] st16();
        return 32'({c16.busy, c16.done, c16.eq, c16.gt, c16.lt});
    endfunction

    function automatic logic [31:0] fl16();
        return 32'({c16.eq, c16.gt, c16.lt});
    endfunction

    // Independent signed/unsigned reference using native signed arithmetic.
    function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b, input logic sm);
        logic signed [8:0] sa;
        logic signed [8:0] sb;
        sa = sm ? {a[7], a} : {1'b0, a};
        sb = sm ? {b[7], b} : {1'b0, b};
        if (sa == sb) return 3'b100;
        else if (sa > sb) return 3'b010;
        else return 3'b001;
    endfunction

    function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b, input int d);
        int ndig;
        ndig = 8 / d;
        if (!EARLY) return ndig;
        for (int i = 7; i >= 0; i--)
            if (a[i] != b[i]) return (7 - i) / d + 1;
        return ndig;
    endfunction

    // Called at #1 after an edge; returns cycles until done (21 on timeout).
    task automatic wait_done16(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (c16.done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) lat = 21;
    endtask

    task automatic cmp16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sm, input logic [2:0] exp_fl, input int exp_lat);
        int lat;
        c16.a = a; c16.b = b; c16.signed_mode = sm; c16.start = 1'b1;
        @(posedge clk); #1;
        c16.start = 1'b0;
        check({tag, "_busy"}, st16(), 32'b10000);
        wait_done16(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, fl16(), 32'(exp_fl));
        @(posedge clk); #1;
        check({tag, "_hold"}, st16(), 32'(exp_fl));
    endtask

    initial begin
        int lat;
        int pulses;
        int first;
        int l1, l2, l8;
        logic [2:0] ef;

        rst_n = 1'b0;
        c16.start = 1'b0; c16.a = '0; c16.b = '0; c16.signed_mode = 1'b0;
        sw_start = 1'b0; sw_a = '0; sw_b = '0; sw_sm = 1'b0;

        // Reset with random activity on the inputs.
        for (int i = 0; i < 5; i++) begin
            c16.start = 1'($urandom); c16.a = 16'($urandom); c16.b = 16'($urandom);
            c16.signed_mode = 1'($urandom);
            sw_start = 1'($urandom); sw_a = 8'($urandom); sw_b = 8'($urandom);
            @(posedge clk); #1;
        end
        check("rst_hold", st16(), 32'b0);
        c16.start = 1'b0; sw_start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_rel16", st16(), 32'b0);
        check("rst_rel8", 32'({c81.busy, c81.done, c82.busy, c82.done, c88.busy, c88.eq, c88.gt, c88.lt}), 32'b0);

        cmp16("u_eq", 16'h1234, 16'h1234, 1'b0, 3'b100, 4);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (c16.done) pulses++;
        end
        check("u_eq_once", 32'(pulses), 32'd0);

        cmp16("u_gt", 16'h8000, 16'h7FFF, 1'b0, 3'b010, EARLY ? 1 : 4);
        cmp16("s_lt", 16'h8000, 16'h0001, 1'b1, 3'b001, EARLY ? 1 : 4);
        cmp16("s_gt", 16'hFFFF, 16'hFFFE, 1'b1, 3'b010, 4);

        // Late difference with a stray start and operand change while busy.
        c16.a = 16'h00A5; c16.b = 16'h00A4; c16.signed_mode = 1'b0; c16.start = 1'b1;
        @(posedge clk); #1;
        pulses = 0; first = 0;
        for (int i = 1; i <= 12; i++) begin
            c16.start = (i == 1);
            if (i == 1) begin
                c16.a = 16'h0000; c16.b = 16'hFFFF; c16.signed_mode = 1'b1;
            end
            @(posedge clk); #1;
            if (c16.done) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("late_pulses", 32'(pulses), 32'd1);
        check("late_lat", 32'(first), 32'd4);
        check("late_res", fl16(), 32'b010);

        // Back-to-back: new start accepted in the done cycle.
        c16.a = 16'h1234; c16.b = 16'h1234; c16.signed_mode = 1'b0; c16.start = 1'b1;
        @(posedge clk); #1;
        c16.start = 1'b0;
        wait_done16(lat);
        check("b2b_first", 32'(lat), 32'd4);
        c16.a = 16'd3; c16.b = 16'd5; c16.start = 1'b1;
        @(posedge clk); #1;
        c16.start = 1'b0;
        check("b2b_busy", st16(), 32'b10000);
        wait_done16(lat);
        check("b2b_lat", 32'(lat), 32'd4);
        check("b2b_res", fl16(), 32'b001);

        // Abort in the second SCAN cycle.
        c16.a = 16'h5555; c16.b = 16'h5555; c16.start = 1'b1;
        @(posedge clk); #1;
        c16.start = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", st16(), 32'b10000);
        #2 rst_n = 1'b0;
        #1 check("abort_clr", st16(), 32'b0);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (c16.done || c16.busy) pulses++;
        end
        check("abort_nodone", 32'(pulses), 32'd0);
        cmp16("s_post", 16'h7FFF, 16'h8000, 1'b1, 3'b010, EARLY ? 1 : 4);

        // Sweep three 8-bit configurations against the reference.
        for (int n = 0; n < 1000; n++) begin
            sw_a = 8'($urandom);
            sw_b = (n % 8 == 0) ? sw_a : 8'($urandom);
            sw_sm = n[0];
            sw_start = 1'b1;
            @(posedge clk); #1;
            sw_start = 1'b0;
            l1 = 0; l2 = 0; l8 = 0;
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk); #1;
                if (c81.done && l1 == 0) l1 = c;
                if (c82.done && l2 == 0) l2 = c;
                if (c88.done && l8 == 0) l8 = c;
                if (l1 != 0 && l2 != 0 && l8 != 0) break;
            end
            ef = ref_flags(sw_a, sw_b, sw_sm);
            check("sw81_res", 32'({c81.eq, c81.gt, c81.lt}), 32'(ef));
            check("sw82_res", 32'({c82.eq, c82.gt, c82.lt}), 32'(ef));
            check("sw88_res", 32'({c88.eq, c88.gt, c88.lt}), 32'(ef));
            check("sw81_lat", 32'(l1), 32'(ref_lat(sw_a, sw_b, 1)));
            check("sw82_lat", 32'(l2), 32'(ref_lat(sw_a, sw_b, 2)));
            check("sw88_lat", 32'(l8), 32'(ref_lat(sw_a, sw_b, 8)));
            check("sw81_rng", 32'(l1 >= 1 && l1 <= 8), 32'd1);
            check("sw82_rng", 32'(l2 >= 1 && l2 <= 4), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
- Multi-cycle N-bit magnitude comparator, the generalised successor of the team's gate-level 1-bit equality comparator.
- Scans two WIDTH-bit operands MSB-first, DIGIT bits per clock, and reports eq/gt/lt through a start/done handshake.
- Supports unsigned and two's-complement signed compare.
- Sits between datapath registers and control FSMs where a full-width single-cycle comparator would break timing.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 2.
- DIGIT, 4, bits compared per cycle; must divide WIDTH exactly, otherwise elaboration error. NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  single-cycle pulse when the result becomes valid.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, eq, gt, lt all 0; internal operand registers and digit index cleared. Reset mid-scan aborts the operation with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE/DONE, start=1 at edge E0:
  - Latch a and b.
  - In signed mode, invert the MSB of both latched operands (offset-binary), so an unsigned digit compare gives the signed order.
  - idx=0 (the MSB digit); clear eq/gt/lt; set busy=1; go to SCAN.
- SCAN, one edge per digit: compare digit idx of A against digit idx of B, where digit 0 is bits [WIDTH-1 -: DIGIT].
  - Digits differ: set gt or lt (see Optional Feature for early-exit policy).
  - Last digit (idx=NDIG-1) processed: set eq=1 if no difference was found. Go to DONE; busy=0.
- DONE: lasts exactly one cycle with done=1.
  - Returns to IDLE, or to SCAN if start=1 in that cycle (back-to-back accepted).
- Result hold: exactly one of eq/gt/lt is 1 from the done cycle until the next accepted start. At most one flag is ever 1; all are 0 while busy.
- Latency: done is high k cycles after the start edge, k = number of digits scanned (1..NDIG). DIGIT=WIDTH gives k=1.
- start while busy=1 is ignored. Operand changes on a/b/signed_mode while busy have no effect.
- Simultaneous start and rst_n low: reset wins.

Optional Feature:
- Macro SEQCOMP_EARLY_EXIT_EN.
- Defined:
  - SCAN ends on the first differing digit; gt/lt set at that edge; k = index of first differing digit + 1.
  - Equal operands always take NDIG cycles.
- Undefined:
  - Constant latency: always scans all NDIG digits (k=NDIG).
  - The first difference is held in a sticky decided flag and later digits do not override it.
  - Results are identical to the defined case; only the done timing differs.

Test Plan (WIDTH=16, DIGIT=4, NDIG=4 unless noted):
- Reset: hold rst_n=0 with random inputs, then release -> busy=done=eq=gt=lt=0; first start produces done exactly once.
- Unsigned: a=16'h1234, b=16'h1234, signed_mode=0 -> eq=1, done 4 cycles after start. a=16'h8000, b=16'h7FFF, signed_mode=0 -> gt=1; done after 1 cycle with SEQCOMP_EARLY_EXIT_EN, after 4 cycles without.
- Signed: a=16'h8000 (-32768), b=16'h0001, signed_mode=1 -> lt=1. a=16'hFFFF, b=16'hFFFE -> gt=1.
- Late difference: a=16'h00A5, b=16'h00A4 -> gt=1, done after 4 cycles in both builds. Start pulsed again while busy -> ignored, exactly one done.
- Back-to-back and abort:
  - Assert start in the DONE cycle with a=3, b=5 -> new compare starts, lt=1 on the next done.
  - Drop rst_n in the second SCAN cycle -> all outputs 0 immediately, no done pulse.
- Parameter sweep: WIDTH=8 with DIGIT=1, 2, 8 -> random 1000 pairs in both modes match a reference model; done latency stays within 1..WIDTH/DIGIT.
